change_dispenser: RTL and testbench

- Payout side of the vending machine. Accepts a change-due amount from the vending controller and pays it out as timed solenoid pulses to four coin-tube hoppers.
- Uses greedy largest-denomination-first selection and skips tubes flagged empty.
- Reports completion, and any amount that could not be paid, back to the controller.

---
 rtl/change_dispenser.sv | 138 +++++++++++++
 tb/tb_change_dispenser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin-tube payout sequencer: greedy largest-first selection, timed solenoid pulses.
// Optional per-tube coin counters are built when COIN_COUNT_EN is defined.
module change_dispenser #(
  parameter int D0           = 50,
  parameter int D1           = 25,
  parameter int D2           = 10,
  parameter int D3           = 5,
  parameter int PULSE_CYCLES = 250000,
  parameter int GAP_CYCLES   = 250000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [7:0]  amount_i,
  input  logic [3:0]  empty_i,
`ifdef COIN_COUNT_EN
  input  logic        clr_cnt_i,
  output logic [31:0] count_o,
`endif
  output logic        busy_o,
  output logic [3:0]  coin_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  rem_o
);

  localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

  state_t          state;
  logic [7:0]      remaining;
  logic [TW-1:0]   timer;
  logic            sel_found;
  logic [1:0]      sel_idx;
  logic [7:0]      sel_val;

  function automatic logic [7:0] denom(input int k);
    case (k)
      0:       return 8'(D0);
      1:       return 8'(D1);
      2:       return 8'(D2);
      default: return 8'(D3);
    endcase
  endfunction

  // Scan smallest to largest so the largest eligible denomination wins.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    sel_val   = 8'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!empty_i[k] && denom(k) <= remaining) begin
        sel_found = 1'b1;
        sel_idx   = 2'(k);
        sel_val   = denom(k);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      remaining <= 8'd0;
      timer     <= '0;
      busy_o    <= 1'b0;
      coin_o    <= 4'b0000;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rem_o     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i) begin
            remaining <= amount_i;
            err_o     <= 1'b0;
            rem_o     <= 8'd0;
            busy_o    <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            remaining <= remaining - sel_val;
            coin_o    <= 4'b0001 << sel_idx;
            timer     <= PULSE_LOAD;
            state     <= PULSE;
          end else begin
            done_o <= 1'b1;
            rem_o  <= remaining;
            err_o  <= |remaining;
            state  <= DONE;
          end
        end
        PULSE: begin
          if (timer == '0) begin
            coin_o <= 4'b0000;
            timer  <= GAP_LOAD;
            state  <= GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer == '0) state <= SELECT;
          else             timer <= timer - TW'(1);
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COIN_COUNT_EN
  logic [7:0] cnt [4];

  // Saturating per-tube tallies, bumped on the SELECT->PULSE transition.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      for (int k = 0; k < 4; k++) cnt[k] <= 8'd0;
    end else if (state == SELECT && sel_found && cnt[sel_idx] != 8'hFF) begin
      cnt[sel_idx] <= cnt[sel_idx] + 8'd1;
    end
  end

  assign count_o = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with short pulse/gap timing.
// Exercises the COIN_COUNT_EN ports too when that macro is defined.
module tb_change_dispenser;

  localparam int P = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [7:0] amount = 8'd0;
  logic [3:0] empty = 4'b0000;
  logic       busy, done, err;
  logic [3:0] coin;
  logic [7:0] rem;
`ifdef COIN_COUNT_EN
  logic        clr_cnt = 1'b0;
  logic [31:0] count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  change_dispenser #(
    .D0(50), .D1(25), .D2(10), .D3(5), .PULSE_CYCLES(P), .GAP_CYCLES(G)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .amount_i (amount),
    .empty_i  (empty),
`ifdef COIN_COUNT_EN
    .clr_cnt_i(clr_cnt),
    .count_o  (count),
`endif
    .busy_o   (busy),
    .coin_o   (coin),
    .done_o   (done),
    .err_o    (err),
    .rem_o    (rem)
  );

  always #5 clk = ~clk;

  // seq lists expected tubes as hex digits, first coin leftmost; inject>0 fires a stray req at that cycle.
  typedef struct packed {
    logic [7:0]  amount;
    logic [3:0]  empty;
    logic [7:0]  inject;
    logic [3:0]  ncoins;
    logic [23:0] seq;
    logic        err;
    logic [7:0]  rem;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Issue one request and watch it at every falling edge; c=0 is the cycle after acceptance.
  task automatic run(input vec_t v, input int idx);
    int   npulse = 0, cur = 0, low = 0, first_c = -1, done_cnt = 0, done_c = -1, busy_cyc = 0;
    int   bad_tube = 0, bad_len = 0, bad_gap = 0, multi = 0;
    bit   in_p = 1'b0, finished = 1'b0;
    logic err_s = 1'b0;
    logic [7:0] rem_s = 8'd0;
    logic [3:0] exp_tube;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    req = 1'b1; amount = v.amount; empty = v.empty;
    @(negedge clk);
    req = 1'b0; amount = 8'hAA;
    for (int c = 0; c < 200; c++) begin
      if (busy) busy_cyc++;
      if (coin != 4'b0000) begin
        if ($countones(coin) != 1) multi++;
        if (!in_p) begin
          if (npulse == 0) first_c = c;
          else if (low != G + 1) bad_gap++;
          if (npulse < int'(v.ncoins)) begin
            exp_tube = v.seq[4*(int'(v.ncoins) - 1 - npulse) +: 4];
            if (coin != (4'b0001 << exp_tube)) bad_tube++;
          end
          npulse++;
          cur  = 1;
          in_p = 1'b1;
        end else begin
          cur++;
        end
      end else if (in_p) begin
        if (cur != P) bad_len++;
        in_p = 1'b0;
        low  = 1;
      end else begin
        low++;
      end
      if (done) begin
        done_cnt++;
        done_c = c;
        err_s  = err;
        rem_s  = rem;
      end
      if (done_cnt > 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      if (v.inject != 8'd0 && c == int'(v.inject)) begin
        req = 1'b1; amount = 8'd50;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check({tag, " finished"},   32'(finished), 32'd1);
    check({tag, " coins"},      32'(npulse), 32'(v.ncoins));
    check({tag, " tube order"}, 32'(bad_tube), 32'd0);
    check({tag, " pulse len"},  32'(bad_len), 32'd0);
    check({tag, " gap len"},    32'(bad_gap), 32'd0);
    check({tag, " onehot"},     32'(multi), 32'd0);
    if (v.ncoins != 4'd0) check({tag, " first pulse"}, 32'(first_c), 32'd1);
    check({tag, " done count"}, 32'(done_cnt), 32'd1);
    check({tag, " err"},        32'(err_s), 32'(v.err));
    check({tag, " rem"},        32'(rem_s), 32'(v.rem));
    // SELECT + (SELECT, pulse, gap) per coin... busy spans one SELECT per coin plus the final SELECT and DONE.
    check({tag, " busy cycles"}, 32'(busy_cyc), 32'(2 + int'(v.ncoins) * (P + G + 1)));
    check({tag, " done cycle"},  32'(done_c), 32'(1 + int'(v.ncoins) * (P + G + 1)));
    check({tag, " err held"},    32'(err), 32'(v.err));
  endtask

  initial begin
    vec_t v10;
    int   stray_done;
    vecs[0] = '{8'd85,  4'b0000, 8'd0,  4'd3, 24'h012,    1'b0, 8'd0};
    vecs[1] = '{8'd100, 4'b0001, 8'd0,  4'd4, 24'h1111,   1'b0, 8'd0};
    vecs[2] = '{8'd7,   4'b0000, 8'd0,  4'd1, 24'h3,      1'b1, 8'd2};
    vecs[3] = '{8'd0,   4'b0000, 8'd0,  4'd0, 24'h0,      1'b0, 8'd0};
    vecs[4] = '{8'd60,  4'b0100, 8'd0,  4'd3, 24'h033,    1'b0, 8'd0};
    vecs[5] = '{8'd255, 4'b0000, 8'd0,  4'd6, 24'h000003, 1'b0, 8'd0};
    vecs[6] = '{8'd30,  4'b1111, 8'd0,  4'd0, 24'h0,      1'b1, 8'd30};
    vecs[7] = '{8'd255, 4'b1110, 8'd0,  4'd5, 24'h00000,  1'b1, 8'd5};
    vecs[8] = '{8'd85,  4'b0000, 8'd10, 4'd3, 24'h012,    1'b0, 8'd0};
    vecs[9] = '{8'd40,  4'b0000, 8'd0,  4'd3, 24'h123,    1'b0, 8'd0};
    v10     = '{8'd10,  4'b0000, 8'd0,  4'd1, 24'h2,      1'b0, 8'd0};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset coin", 32'(coin), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err",  32'(err),  32'd0);
    check("reset rem",  32'(rem),  32'd0);
`ifdef COIN_COUNT_EN
    check("reset count", count, 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(vecs[i], i);

    // Abort with reset in the second cycle of the first pulse.
    @(negedge clk);
    req = 1'b1; amount = 8'd85; empty = 4'b0000;
    @(negedge clk);
    req = 1'b0;
    check("abort select busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort pulse c1", 32'(coin), 32'd1);
    @(negedge clk);
    check("abort pulse c2", 32'(coin), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort coin", 32'(coin), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
`ifdef COIN_COUNT_EN
    check("abort count", count, 32'd0);
`endif
    rst = 1'b0;
    stray_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy || coin != 4'b0000) stray_done++;
    end
    check("abort quiet", 32'(stray_done), 32'd0);

    run(v10, 10);
`ifdef COIN_COUNT_EN
    check("count after 10", count, 32'h0001_0000);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("count cleared", count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
